// File: rtl/dac_spi_receiver_pkg.sv
// +----------------------------------------------------------------------+
// | dac_pkg                                                              |
// | Shared types and field positions for the MCP4922 write-word decoder. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dac_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam int WORD_BITS = 16;
   localparam int CODE_BITS = 12;

   localparam int AB_BIT   = 15;
   localparam int BUF_BIT  = 14;
   localparam int GA_BIT   = 13;
   localparam int SHDN_BIT = 12;

   localparam int          CNT_BITS = 5;
   localparam logic [4:0]  CNT_FULL = 5'd16;
   localparam logic [4:0]  CNT_SAT  = 5'd17;

endpackage

`default_nettype wire

// File: rtl/dac_spi_receiver_sync_edge.sv
// +----------------------------------------------------------------------+
// | sync_edge                                                            |
// | Multi-flop synchronizer with registered rise/fall strobes.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // level is the delayed copy so it lines up with the registered strobes.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
      fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign level = prev_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/dac_spi_receiver.sv
// +----------------------------------------------------------------------+
// | dac_spi_receiver                                                     |
// | MCP4922-compatible SPI slave with double-buffered A/B outputs.       |
// | Optional macro DAC_FRAME_CHECK_EN enables frame_err / err_count.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dac_spi_receiver
   import dac_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dac_sclk,
   input  logic        dac_mosi,
   input  logic        dac_CSN,
   input  logic        dac_latch,
   output logic [11:0] dac_a_out,
   output logic [11:0] dac_b_out,
   output logic [5:0]  chan_cfg,
   output logic        word_valid,
   output logic [15:0] word_data,
   output logic        frame_err,
   output logic [7:0]  err_count
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic csn_lvl,  csn_rise,  csn_fall;
   logic ldac_lvl, ldac_rise, ldac_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
      .clk(clk), .rst(rst), .din(dac_sclk),
      .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
   );
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csn (
      .clk(clk), .rst(rst), .din(dac_CSN),
      .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
   );
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ldac (
      .clk(clk), .rst(rst), .din(dac_latch),
      .level(ldac_lvl), .rise(ldac_rise), .fall(ldac_fall)
   );
   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
      .clk(clk), .rst(rst), .din(dac_mosi),
      .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
   );

   logic unused_edges;
   assign unused_edges = ^{sclk_lvl, sclk_fall, csn_lvl, ldac_rise, ldac_fall,
                           mosi_rise, mosi_fall};

   state_t                state_q, state_d;
   logic [WORD_BITS-1:0]  shift_q, shift_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [CODE_BITS-1:0]  in_a_q, in_a_d, in_b_q, in_b_d;
   logic [CODE_BITS-1:0]  out_a_q, out_a_d, out_b_q, out_b_d;
   logic [5:0]            cfg_q, cfg_d;
   logic                  word_valid_q, word_valid_d;
   logic [WORD_BITS-1:0]  word_data_q, word_data_d;
   logic                  commit_bad;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      in_a_d       = in_a_q;
      in_b_d       = in_b_q;
      cfg_d        = cfg_q;
      word_valid_d = 1'b0;
      word_data_d  = word_data_q;
      commit_bad   = 1'b0;

      case (state_q)
         IDLE: begin
            if (csn_fall) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               state_d = COMMIT;
            end else if (sclk_rise) begin
               shift_d = {shift_q[WORD_BITS-2:0], mosi_lvl};
               if (cnt_q != CNT_SAT) begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         COMMIT: begin
            state_d = IDLE;
            if (cnt_q == CNT_FULL) begin
               word_valid_d = 1'b1;
               word_data_d  = shift_q;
               if (!shift_q[AB_BIT]) begin
                  in_a_d     = shift_q[CODE_BITS-1:0];
                  cfg_d[5:3] = shift_q[BUF_BIT:SHDN_BIT];
               end else begin
                  in_b_d     = shift_q[CODE_BITS-1:0];
                  cfg_d[2:0] = shift_q[BUF_BIT:SHDN_BIT];
               end
            end else begin
               commit_bad = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // LDAC low copies input to output every cycle; a same-cycle commit lands one cycle later.
   always_comb begin
      out_a_d = out_a_q;
      out_b_d = out_b_q;
      if (!ldac_lvl) begin
         out_a_d = in_a_q;
         out_b_d = in_b_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         in_a_q       <= '0;
         in_b_q       <= '0;
         out_a_q      <= '0;
         out_b_q      <= '0;
         cfg_q        <= '0;
         word_valid_q <= 1'b0;
         word_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         in_a_q       <= in_a_d;
         in_b_q       <= in_b_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
         cfg_q        <= cfg_d;
         word_valid_q <= word_valid_d;
         word_data_q  <= word_data_d;
      end
   end

`ifdef DAC_FRAME_CHECK_EN
   logic       frame_err_q, frame_err_d;
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      frame_err_d = commit_bad;
      err_count_d = err_count_q;
      if (commit_bad && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         frame_err_q <= frame_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign frame_err = frame_err_q;
   assign err_count = err_count_q;
`else
   logic unused_commit_bad;
   assign unused_commit_bad = commit_bad;
   assign frame_err         = 1'b0;
   assign err_count         = '0;
`endif

   // Shutdown masks the pin value only; stored codes survive.
   assign dac_a_out  = cfg_q[3] ? out_a_q : '0;
   assign dac_b_out  = cfg_q[0] ? out_b_q : '0;
   assign chan_cfg   = cfg_q;
   assign word_valid = word_valid_q;
   assign word_data  = word_data_q;

endmodule

`default_nettype wire
